// File: rtl/dnn_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dnn_arb_pkg
// Description : Shared types and constants for the two-port SDRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dnn_arb_pkg;

  // Number of requesters sharing the SDRAM controller.
  localparam int NREQ = 2;

  // Requester identifier; also the tag stored per outstanding read.
  typedef logic [0:0] req_id_t;

  // Arbiter command-phase state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage : dnn_arb_pkg
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_tag_fifo
// Description : 1-bit wide tag FIFO recording which requester owns each
//               outstanding read. Full/empty come from the registered count.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_tag_fifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Flags are derived only from the registered count, so a pop in the same
  // cycle never makes room for a push in that cycle.
  assign full      = (r_count == C_FULL_CNT);
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : arb_tag_fifo
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Round-robin arbiter multiplexing two Avalon-MM requesters onto
//               one SDRAM controller port, with in-order read-data routing.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
  import dnn_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0][AW-1:0]  req_address,
  input  logic [NREQ-1:0]          req_read,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ-1:0][DW-1:0]  req_writedata,
  output logic [NREQ-1:0]          req_waitrequest,
  output logic [DW-1:0]            req_readdata,
  output logic [NREQ-1:0]          req_readdatavalid,
  output logic [AW-1:0]            m_address,
  output logic                     m_read,
  output logic                     m_write,
  output logic [DW-1:0]            m_writedata,
  input  logic                     m_waitrequest,
  input  logic [DW-1:0]            m_readdata,
  input  logic                     m_readdatavalid,
  output logic                     rsp_err
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  req_id_t         r_g;
  req_id_t         r_rr;
  req_id_t         w_grant_sel;
  logic [NREQ-1:0] w_elig;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_fifo_head;

  // A read needs a free tag slot; a write-only request never does. A request
  // with both read and write set is a read, so it also waits on the FIFO.
  for (genvar i = 0; i < NREQ; i++) begin : g_elig
    assign w_elig[i] = (req_read[i] & ~w_fifo_full) | (req_write[i] & ~req_read[i]);
  end

  assign w_grant_sel  = w_elig[r_rr] ? r_rr : ~r_rr;
  assign w_push       = w_accept & m_read;
  assign w_pop        = m_readdatavalid & ~w_fifo_empty & ~rst;
  assign req_readdata = m_readdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and command-phase outputs; reset forces a quiet command port.
  always_comb begin
    w_state_nxt     = r_state;
    w_accept        = 1'b0;
    m_address       = '0;
    m_writedata     = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    req_waitrequest = '1;
    case (r_state)
      IDLE: begin
        if (|w_elig) w_state_nxt = BUSY;
      end
      BUSY: begin
        m_address   = req_address[r_g];
        m_writedata = req_writedata[r_g];
        m_read      = req_read[r_g];
        m_write     = req_write[r_g] & ~req_read[r_g];
        if (!m_waitrequest) begin
          w_accept             = 1'b1;
          req_waitrequest[r_g] = 1'b0;
          w_state_nxt          = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      w_state_nxt     = IDLE;
      w_accept        = 1'b0;
      m_address       = '0;
      m_writedata     = '0;
      m_read          = 1'b0;
      m_write         = 1'b0;
      req_waitrequest = '1;
    end
  end

  // Grant is latched on entry to BUSY; the pointer moves past the winner on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g  <= '0;
      r_rr <= '0;
    end else begin
      if (r_state == IDLE && (|w_elig)) r_g <= w_grant_sel;
      if (w_accept) r_rr <= ~r_g;
    end
  end

  // Route returning read data to the owner of the oldest outstanding tag.
  always_comb begin
    req_readdatavalid = '0;
    if (w_pop) req_readdatavalid[w_fifo_head] = 1'b1;
  end

  // Sticky flag for read data arriving with no read outstanding.
  always_ff @(posedge clk) begin
    if (rst)                                  rsp_err <= 1'b0;
    else if (m_readdatavalid && w_fifo_empty) rsp_err <= 1'b1;
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_g[0]),
    .pop       (w_pop),
    .head      (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_OUTST = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0][AW-1:0]  req_address;
  logic [1:0]          req_read;
  logic [1:0]          req_write;
  logic [1:0][DW-1:0]  req_writedata;
  logic [1:0]          req_waitrequest;
  logic [DW-1:0]       req_readdata;
  logic [1:0]          req_readdatavalid;
  logic [AW-1:0]       m_address;
  logic                m_read;
  logic                m_write;
  logic [DW-1:0]       m_writedata;
  logic                m_waitrequest;
  logic [DW-1:0]       m_readdata;
  logic                m_readdatavalid;
  logic                rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .m_address         (m_address),
    .m_read            (m_read),
    .m_write           (m_write),
    .m_writedata       (m_writedata),
    .m_waitrequest     (m_waitrequest),
    .m_readdata        (m_readdata),
    .m_readdatavalid   (m_readdatavalid),
    .rsp_err           (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle to observe outputs.
  task automatic sample;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst             = 1'b1;
    req_read        = 2'b00;
    req_write       = 2'b00;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    req_address     = '0;
    req_writedata   = '0;
    req_read        = 2'b11;
    req_write       = 2'b00;
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;

    // ---- reset behaviour ----
    sample();
    chk("rst_waitreq", 32'(req_waitrequest), 32'h3);
    chk("rst_m_read", 32'(m_read), 32'h0);
    chk("rst_m_write", 32'(m_write), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    req_address[0] = 32'h10;
    req_address[1] = 32'h20;
    sample();
    chk("post_rst_waitreq", 32'(req_waitrequest), 32'h3);
    chk("post_rst_m_read", 32'(m_read), 32'h0);
    chk("post_rst_m_address", m_address, 32'h0);
    chk("post_rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("post_rst_rdv", 32'(req_readdatavalid), 32'h0);

    // ---- alternating grants, both reading ----
    tick(); sample();
    chk("alt_g0_waitreq", 32'(req_waitrequest), 32'h2);
    chk("alt_g0_m_read", 32'(m_read), 32'h1);
    chk("alt_g0_addr", m_address, 32'h10);
    tick(); sample();
    chk("alt_idle_waitreq", 32'(req_waitrequest), 32'h3);
    chk("alt_idle_m_read", 32'(m_read), 32'h0);
    tick(); sample();
    chk("alt_g1_waitreq", 32'(req_waitrequest), 32'h1);
    chk("alt_g1_addr", m_address, 32'h20);
    tick(); sample();
    chk("alt_idle2_waitreq", 32'(req_waitrequest), 32'h3);
    tick(); sample();
    chk("alt_g0b_waitreq", 32'(req_waitrequest), 32'h2);

    // ---- stalled write is held, no preemption ----
    do_reset();
    m_waitrequest    = 1'b1;
    req_write        = 2'b01;
    req_address[0]   = 32'h100;
    req_writedata[0] = 32'hDEAD;
    req_read         = 2'b10;
    req_address[1]   = 32'h200;
    sample();
    chk("wr_idle_m_write", 32'(m_write), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(); sample();
      chk("wr_stall_m_write", 32'(m_write), 32'h1);
      chk("wr_stall_addr", m_address, 32'h100);
      chk("wr_stall_waitreq", 32'(req_waitrequest), 32'h3);
    end
    tick();
    m_waitrequest = 1'b0;
    sample();
    chk("wr_accept_waitreq", 32'(req_waitrequest), 32'h2);
    chk("wr_accept_wdata", m_writedata, 32'hDEAD);
    tick();
    req_write = 2'b00;
    sample();
    chk("wr_after_idle_waitreq", 32'(req_waitrequest), 32'h3);
    chk("wr_after_idle_m_write", 32'(m_write), 32'h0);
    tick(); sample();
    chk("wr_then_r1_waitreq", 32'(req_waitrequest), 32'h1);
    chk("wr_then_r1_m_read", 32'(m_read), 32'h1);
    chk("wr_then_r1_addr", m_address, 32'h200);

    // ---- tag FIFO full blocks reads but not writes ----
    do_reset();
    req_read       = 2'b10;
    req_address[1] = 32'h40;
    for (int k = 0; k < 8; k++) begin
      tick(); sample();
      chk("full_fill_waitreq", 32'(req_waitrequest), 32'h1);
      tick();
    end
    req_write      = 2'b01;
    req_address[0] = 32'h300;
    sample();
    chk("full_idle_waitreq", 32'(req_waitrequest), 32'h3);
    tick(); sample();
    chk("full_write_m_write", 32'(m_write), 32'h1);
    chk("full_write_addr", m_address, 32'h300);
    chk("full_write_waitreq", 32'(req_waitrequest), 32'h2);
    tick();
    req_write = 2'b00;
    sample();
    chk("full_read_blocked1", 32'(req_waitrequest), 32'h3);
    tick(); sample();
    chk("full_read_blocked2", 32'(req_waitrequest), 32'h3);
    chk("full_read_blocked_m_read", 32'(m_read), 32'h0);
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h55;
    #1;
    chk("full_pop_rdv", 32'(req_readdatavalid), 32'h2);
    chk("full_pop_rdata", req_readdata, 32'h55);
    tick();
    m_readdatavalid = 1'b0;
    sample();
    chk("full_unblock_plus1", 32'(req_waitrequest), 32'h3);
    tick(); sample();
    chk("full_unblock_plus2", 32'(req_waitrequest), 32'h1);
    chk("full_unblock_m_read", 32'(m_read), 32'h1);
    tick();
    req_read = 2'b00;

    // ---- in-order read data routing ----
    do_reset();
    req_read = 2'b01;
    tick(); sample();
    chk("ord_g0_waitreq", 32'(req_waitrequest), 32'h2);
    tick();
    req_read = 2'b10;
    tick(); sample();
    chk("ord_g1_waitreq", 32'(req_waitrequest), 32'h1);
    tick();
    req_read = 2'b01;
    tick(); sample();
    chk("ord_g0b_waitreq", 32'(req_waitrequest), 32'h2);
    tick();
    req_read        = 2'b00;
    m_readdatavalid = 1'b1;
    m_readdata      = 32'hA;
    sample();
    chk("ord_rdv_a", 32'(req_readdatavalid), 32'h1);
    chk("ord_data_a", req_readdata, 32'hA);
    tick();
    m_readdata = 32'hB;
    sample();
    chk("ord_rdv_b", 32'(req_readdatavalid), 32'h2);
    chk("ord_data_b", req_readdata, 32'hB);
    tick();
    m_readdata = 32'hC;
    sample();
    chk("ord_rdv_c", 32'(req_readdatavalid), 32'h1);
    chk("ord_data_c", req_readdata, 32'hC);
    tick();
    m_readdatavalid = 1'b0;
    sample();
    chk("ord_rsp_err", 32'(rsp_err), 32'h0);

    // ---- orphan read data ----
    tick();
    m_readdatavalid = 1'b1;
    m_readdata      = 32'h77;
    sample();
    chk("orphan_rdv", 32'(req_readdatavalid), 32'h0);
    tick();
    m_readdatavalid = 1'b0;
    sample();
    chk("orphan_rsp_err", 32'(rsp_err), 32'h1);
    tick(); tick(); sample();
    chk("orphan_sticky", 32'(rsp_err), 32'h1);
    do_reset();
    sample();
    chk("orphan_cleared", 32'(rsp_err), 32'h0);

    // ---- reset mid-transaction with two reads outstanding ----
    tick();
    req_read = 2'b01;
    tick();
    tick();
    req_read = 2'b10;
    tick();
    tick();
    m_waitrequest = 1'b1;
    req_read      = 2'b01;
    tick(); sample();
    chk("rstmid_busy_m_read", 32'(m_read), 32'h1);
    chk("rstmid_busy_waitreq", 32'(req_waitrequest), 32'h3);
    rst = 1'b1;
    #1;
    chk("rstmid_in_rst_m_read", 32'(m_read), 32'h0);
    chk("rstmid_in_rst_waitreq", 32'(req_waitrequest), 32'h3);
    tick();
    rst           = 1'b0;
    req_read      = 2'b00;
    m_waitrequest = 1'b0;
    sample();
    chk("rstmid_after_waitreq", 32'(req_waitrequest), 32'h3);
    chk("rstmid_after_m_read", 32'(m_read), 32'h0);
    chk("rstmid_after_rsp_err", 32'(rsp_err), 32'h0);
    tick();
    m_readdatavalid = 1'b1;
    sample();
    chk("rstmid_late_rdv", 32'(req_readdatavalid), 32'h0);
    tick(); sample();
    chk("rstmid_late_rsp_err", 32'(rsp_err), 32'h1);
    chk("rstmid_late_rdv2", 32'(req_readdatavalid), 32'h0);
    tick();
    m_readdatavalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sdram_arbiter
`default_nettype wire
